rv_byte_packer: RTL and testbench

//   Packs the 8-bit ready/valid byte stream leaving the byte FIFO into WORD_BYTES-wide words.

---
 rtl/rv_byte_packer.sv | 115 +++++++++++
 tb/tb_rv_byte_packer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_byte_packer.sv
// Packs a byte-wide ready/valid stream into WORD_BYTES-wide words, with a flush
// that emits a partially filled word together with its byte-enable mask.
module rv_byte_packer #(
    parameter int WORD_BYTES = 4,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                             clock_port,
    input  logic                             reset_port,
    input  logic [BYTE_WIDTH-1:0]            input_port_data,
    input  logic                             input_port_valid,
    output logic                             input_port_ready,
    output logic [WORD_BYTES*BYTE_WIDTH-1:0] output_port_data,
    output logic [WORD_BYTES-1:0]            output_port_mask,
    output logic                             output_port_valid,
    input  logic                             output_port_ready,
    input  logic                             flush,
    output logic                             flush_busy
);
    localparam int CW = $clog2(WORD_BYTES);
    localparam int NW = $clog2(WORD_BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);

    logic [WORD_BYTES-2:0][BYTE_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]                         cnt_q, cnt_d;
    logic [WORD_BYTES-1:0][BYTE_WIDTH-1:0] out_data_q, out_data_d, word;
    logic [WORD_BYTES-1:0]                 out_mask_q, out_mask_d, mask;
    logic                                  out_valid_q, out_valid_d;
    logic                                  flush_pend_q, flush_pend_d;
    logic                                  slot_free, accept, flush_req, load, store;
    logic [NW-1:0]                         n;

    assign slot_free        = ~out_valid_q | output_port_ready;
    assign input_port_ready = ~flush_pend_q & ((cnt_q != LAST) | slot_free);
    assign accept           = input_port_valid & input_port_ready;
    assign flush_req        = flush | flush_pend_q;
    assign n                = NW'(cnt_q) + NW'(accept);

    // Candidate output word: accumulated bytes, then the byte accepted this
    // cycle at slot cnt, zeros above. Serves both full loads and flushes.
    for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
        if (i < WORD_BYTES - 1) begin : g_acc
            assign word[i] = (NW'(i) < NW'(cnt_q)) ? acc_q[i] :
                             ((NW'(i) == NW'(cnt_q)) && accept) ? input_port_data : '0;
        end else begin : g_top
            assign word[i] = (accept && (cnt_q == LAST)) ? input_port_data : '0;
        end
        assign mask[i] = (NW'(i) < n);
    end

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        out_mask_d   = out_mask_q;
        out_valid_d  = out_valid_q;
        flush_pend_d = flush_pend_q;
        load         = 1'b0;
        store        = 1'b0;

        if (accept && (cnt_q == LAST)) begin
            load = 1'b1;
        end else if (flush_req) begin
            if (n == '0) begin
                flush_pend_d = 1'b0;
            end else if (slot_free) begin
                load         = 1'b1;
                flush_pend_d = 1'b0;
            end else begin
                flush_pend_d = 1'b1;
                store        = accept;
            end
        end else begin
            store = accept;
        end

        if (store) begin
            for (int i = 0; i < WORD_BYTES - 1; i++)
                if (cnt_q == CW'(i)) acc_d[i] = input_port_data;
            cnt_d = cnt_q + CW'(1);
        end

        // A new word overrides the handshake so the slot reloads without a gap.
        if (load) begin
            out_data_d  = word;
            out_mask_d  = mask;
            out_valid_d = 1'b1;
            cnt_d       = '0;
        end else if (out_valid_q && output_port_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_port or posedge reset_port) begin
        if (reset_port) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_mask_q   <= '0;
            out_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_mask_q   <= out_mask_d;
            out_valid_q  <= out_valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign output_port_data  = out_data_q;
    assign output_port_mask  = out_mask_q;
    assign output_port_valid = out_valid_q;
    assign flush_busy        = flush_pend_q;
endmodule

// File: tb/tb_rv_byte_packer.sv
// Bench for rv_byte_packer: directed vector table, hand-written stall/flush/reset
// sequences, and random traffic against a queue-based reference model.
module tb_rv_byte_packer;
    localparam int WB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  idata;
    logic        ivalid, irdy;
    logic [31:0] odata;
    logic [3:0]  omask;
    logic        ovalid, ordy, flush, busy;

    always #5 clk = ~clk;

    rv_byte_packer #(.WORD_BYTES(WB), .BYTE_WIDTH(8)) dut (
        .clock_port       (clk),
        .reset_port       (rst),
        .input_port_data  (idata),
        .input_port_valid (ivalid),
        .input_port_ready (irdy),
        .output_port_data (odata),
        .output_port_mask (omask),
        .output_port_valid(ovalid),
        .output_port_ready(ordy),
        .flush            (flush),
        .flush_busy       (busy)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: bytes of the partial word, the held output word, flush pending.
    logic [7:0]  part[$];
    bit          mvalid, mpend;
    logic [31:0] mdata;
    logic [3:0]  mmask;
    logic        s_rdy;

    task automatic mreset();
        part.delete();
        mvalid = 0; mpend = 0; mdata = '0; mmask = '0;
    endtask

    // One clock: drive inputs just after a falling edge, check ready, advance the
    // model, then check registered outputs at the following falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
        bit slot, erdy, acc, nw;
        logic [31:0] w;
        ivalid = v; idata = d; flush = f; ordy = r;
        #1;
        s_rdy = irdy;
        slot  = !mvalid || r;
        erdy  = !mpend && (part.size() != WB - 1 || slot);
        chk("in_ready", irdy, erdy);
        acc = v && erdy;
        if (acc) part.push_back(d);
        nw = 0;
        if (part.size() == WB) nw = 1;
        else if (f || mpend) begin
            if (part.size() == 0) mpend = 0;
            else if (slot) begin nw = 1; mpend = 0; end
            else mpend = 1;
        end
        if (nw) begin
            w = '0;
            foreach (part[i]) w |= 32'(part[i]) << (8 * i);
            mdata  = w;
            mmask  = 4'((1 << part.size()) - 1);
            mvalid = 1;
            part.delete();
        end else if (mvalid && r) mvalid = 0;
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", ovalid, mvalid);
        chk("flush_busy", busy, mpend);
        if (mvalid) begin
            chk("out_data", odata, mdata);
            chk("out_mask", omask, mmask);
        end
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        f;
        logic        r;
        logic        erdy;
        logic        evalid;
        logic [31:0] edata;
        logic [3:0]  emask;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [7:0] d, logic f, logic r,
                                logic erdy, logic evalid, logic [31:0] edata, logic [3:0] emask);
        vec_t t;
        t.v = v; t.d = d; t.f = f; t.r = r;
        t.erdy = erdy; t.evalid = evalid; t.edata = edata; t.emask = emask;
        return t;
    endfunction

    initial begin
        // Full words, flush of a partial word, flush on the 4th byte, empty flush.
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(1, 8'(i), 0, 1, 1, (i % 4 == 0),
                             (i == 4) ? 32'h04030201 : 32'h08070605, 4'hF));
        tbl.push_back(mk(1, 8'h11, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h22, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 1, 32'h00002211, 4'h3));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h31, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h32, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h33, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h34, 1, 1, 1, 1, 32'h34333231, 4'hF));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0));

        rst = 1; ivalid = 0; idata = '0; flush = 0; ordy = 1;
        mreset();
        #2;
        chk("rst_valid", ovalid, 1'b0);
        chk("rst_mask", omask, 4'h0);
        chk("rst_data", odata, 32'h0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 0;

        foreach (tbl[k]) begin
            step(tbl[k].v, tbl[k].d, tbl[k].f, tbl[k].r);
            chk($sformatf("tbl%0d_rdy", k), s_rdy, tbl[k].erdy);
            chk($sformatf("tbl%0d_valid", k), ovalid, tbl[k].evalid);
            if (tbl[k].evalid) begin
                chk($sformatf("tbl%0d_data", k), odata, tbl[k].edata);
                chk($sformatf("tbl%0d_mask", k), omask, tbl[k].emask);
            end
        end

        // Stalled output: three more bytes fit, the fourth waits, then reloads gap-free.
        for (int i = 0; i < 4; i++) step(1, 8'(8'h41 + i), 0, 0);
        for (int i = 4; i < 7; i++) begin
            step(1, 8'(8'h41 + i), 0, 0);
            chk("stall_acc_rdy", s_rdy, 1'b1);
        end
        step(1, 8'h48, 0, 0);
        chk("stall_byte8_rdy", s_rdy, 1'b0);
        chk("stall_held", odata, 32'h44434241);
        step(1, 8'h48, 0, 1);
        chk("release_rdy", s_rdy, 1'b1);
        chk("reload_valid", ovalid, 1'b1);
        chk("reload_data", odata, 32'h48474645);
        step(0, 0, 0, 1);

        // Flush while the output slot is stalled stays pending until it frees.
        for (int i = 0; i < 4; i++) step(1, 8'(8'h51 + i), 0, 0);
        step(1, 8'h55, 0, 0);
        step(1, 8'h56, 0, 0);
        step(0, 0, 1, 0);
        chk("pend_busy", busy, 1'b1);
        step(1, 8'h57, 0, 0);
        chk("pend_rdy", s_rdy, 1'b0);
        chk("pend_held", odata, 32'h54535251);
        step(0, 0, 0, 1);
        chk("pend_word", odata, 32'h00005655);
        chk("pend_mask", omask, 4'h3);
        chk("pend_clear", busy, 1'b0);
        step(0, 0, 0, 1);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 7; i++) step(1, 8'(8'h61 + i), 0, 0);
        step(0, 0, 1, 0);
        chk("pre_rst_busy", busy, 1'b1);
        ivalid = 0; flush = 0; ordy = 1;
        #2 rst = 1;
        #1;
        chk("arst_valid", ovalid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_mask", omask, 4'h0);
        @(negedge clk);
        rst = 0;
        mreset();
        for (int i = 0; i < 4; i++) step(1, 8'(8'h71 + i), 0, 1);
        chk("restart_word", odata, 32'h74737271);

        // Random traffic checked against the model.
        for (int c = 0; c < 3000; c++)
            step(($urandom_range(9) < 7), 8'($urandom), ($urandom_range(19) == 0),
                 ($urandom_range(9) < 6));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
